writeback_unit: RTL and testbench
=================================

# writeback_unit

Writeback stage of the core, driving the single write port of the register file. It accepts completed results from the ALU and from the load/store unit over valid/ready handshakes. Loads are buffered in a small FIFO, sign- or zero-extended per RISC-V load type, and arbitrated against ALU results onto one registered write port (`waddr_o`/`wdata_o`/`we_o`).

## Interface
**Parameters**
- `ADDR_WIDTH`, 5, register address width
- `DATA_WIDTH`, 32, data width; load extension logic requires 32
- `LSU_FIFO_DEPTH`, 2, load buffer entries; power of two, ≥2

**Ports**
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `alu_valid_i`  in  1  ALU result valid
- `alu_ready_o`  out  1  ALU result accepted this cycle when high with valid
- `alu_rd_i`  in  ADDR_WIDTH  ALU destination register
- `alu_result_i`  in  DATA_WIDTH  ALU result
- `lsu_valid_i`  in  1  load data valid
- `lsu_ready_o`  out  1  load buffer not full
- `lsu_rd_i`  in  ADDR_WIDTH  load destination register
- `lsu_rdata_i`  in  32  raw aligned memory word
- `lsu_funct3_i`  in  3  load type
- `lsu_offset_i`  in  2  byte offset within word
- `waddr_o`  out  ADDR_WIDTH  register file write address
- `wdata_o`  out  DATA_WIDTH  register file write data
- `we_o`  out  1  register file write enable
- `busy_o`  out  1  load buffer non-empty

## Operation
- Handshake: transfer occurs on a rising edge where valid and ready are both high. Once valid is asserted, the producer holds it and its payload stable until the transfer.
- Ready outputs depend only on internal state, never on the valid inputs.
- Load buffer: a circular FIFO of `LSU_FIFO_DEPTH` entries, each holding {rd, rdata, funct3, offset}. It uses read and write pointers with a count.
- `lsu_ready_o` = count < depth. A full FIFO does not accept a load, even in a cycle where it dequeues.
- Arbitration is fixed priority. If the FIFO is non-empty, the head is dequeued and written, and `alu_ready_o` = 0. Otherwise `alu_ready_o` = 1. Loads always win, which keeps writeback ordered relative to in-order issue.
- Load extension is applied at dequeue. It uses `b = rdata[8*offset +: 8]` and `h = rdata[16*offset[1] +: 16]`; `offset[0]` is ignored for halfwords.
  - 000 LB: sign-extend b
  - 001 LH: sign-extend h
  - 010 LW: rdata
  - 100 LBU: zero-extend b
  - 101 LHU: zero-extend h
  - 011/110/111: treated as LW
- rd = 0: the handshake completes normally, but `we_o` stays 0 for that result. `waddr_o`/`wdata_o` still update.
- Output register update each cycle:
  - `we_o` = (selected source transferred) && rd ≠ 0
  - `waddr_o`/`wdata_o` load the selected source
  - With no transfer, `we_o` = 0 and `waddr_o`/`wdata_o` hold their values.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - FIFO empty, pointers and count 0
  - `we_o` = 0, `waddr_o` = 0, `wdata_o` = 0
  - After reset: `alu_ready_o` = 1, `lsu_ready_o` = 1, `busy_o` = 0
- Reset mid-operation: buffered loads are discarded, and in-flight handshakes in the reset cycle are not accepted.
- ALU latency: transfer at edge N gives `we_o` high during cycle N→N+1 (one cycle).
- Load latency:
  - Enqueue at edge N; earliest dequeue at edge N+1; `we_o` high after edge N+1 (two cycles).
  - No bypass around an empty FIFO.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. Pointers wrap modulo depth.
- Throughput: one register write per cycle maximum.

## Configuration
- `WB_LOAD_EXT_EN`
  - Defined: the load extension and byte/half selection above are compiled in.
  - Undefined: funct3 and offset are neither stored nor used; every load writes `lsu_rdata_i` unmodified (LW behaviour).
  - Handshake, FIFO and arbitration are identical in both builds.

## Test plan
- **Reset:** after reset, `we_o`=0, `waddr_o`=0, `wdata_o`=0, `alu_ready_o`=1, `lsu_ready_o`=1, `busy_o`=0.
- **ALU write:** ALU rd=5, result 0x1234_5678 at edge N → `we_o`=1, `waddr_o`=5, `wdata_o`=0x1234_5678 for exactly one cycle after edge N. ALU rd=0 → transfer completes, `we_o`=0.
- **Load extension (`WB_LOAD_EXT_EN`):** rdata 0x80FF_7F01, rd=7:
  - LB offset 3 → 0xFFFF_FF80
  - LBU offset 2 → 0x0000_00FF
  - LH offset 2 → 0xFFFF_80FF
  - LHU offset 0 → 0x0000_7F01
  - funct3 111 → 0x80FF_7F01
  - Without the macro, all five cases write 0x80FF_7F01.
- **Priority/ordering:** a load (rd=3) and an ALU result (rd=4) are both valid continuously from edge N:
  - Load enqueued at N, `alu_ready_o`=0 during N→N+1
  - rd=3 written after N+1, rd=4 transferred at N+2
- **Full/wrap:** 3 back-to-back loads with depth 2 and ALU idle:
  - `lsu_ready_o` drops only when count reaches 2 without a dequeue
  - All three written in order, rd sequence preserved across pointer wrap
  - `busy_o` falls the cycle after the last dequeue
- **Reset mid-operation:** 2 loads buffered, then `rst_n`=0 for one edge → `busy_o`=0, `we_o`=0; the discarded loads are never written.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: register-file writeback stage; buffers loads in a small FIFO and
// arbitrates them (fixed priority) against ALU results onto one registered write port.
// Optional feature macro: WB_LOAD_EXT_EN compiles in RISC-V load byte/half selection
// and sign/zero extension; without it every load writes the raw memory word.
module writeback_unit #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int LSU_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [ADDR_WIDTH-1:0] alu_rd_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
    input  logic [31:0]           lsu_rdata_i,
    input  logic [2:0]            lsu_funct3_i,
    input  logic [1:0]            lsu_offset_i,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  we_o,
    output logic                  busy_o
);
    localparam int PTR_W = $clog2(LSU_FIFO_DEPTH);
    localparam int CNT_W = $clog2(LSU_FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LSU_FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] r_rd_mem   [LSU_FIFO_DEPTH];
    logic [31:0]           r_data_mem [LSU_FIFO_DEPTH];
`ifdef WB_LOAD_EXT_EN
    logic [2:0]            r_f3_mem   [LSU_FIFO_DEPTH];
    logic [1:0]            r_off_mem  [LSU_FIFO_DEPTH];
`endif
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_alu_xfer;
    logic [ADDR_WIDTH-1:0] w_head_rd;
    logic [31:0]           w_head_data;
    logic [31:0]           w_load_data;

    // Ready signals come purely from FIFO occupancy, never from the valid inputs.
    // A full FIFO refuses a load even while it dequeues; a non-empty FIFO always
    // dequeues, which is what stalls the ALU.
    assign w_empty     = r_count == '0;
    assign w_full      = r_count == DEPTH_C;
    assign lsu_ready_o = !w_full;
    assign alu_ready_o = w_empty;
    assign busy_o      = !w_empty;
    assign w_enq       = lsu_valid_i && !w_full;
    assign w_deq       = !w_empty;
    assign w_alu_xfer  = alu_valid_i && w_empty;
    assign w_head_rd   = r_rd_mem[r_rptr];
    assign w_head_data = r_data_mem[r_rptr];

    assign waddr_o = r_waddr;
    assign wdata_o = r_wdata;
    assign we_o    = r_we;

`ifdef WB_LOAD_EXT_EN
    logic [2:0]  w_head_f3;
    logic [1:0]  w_head_off;
    logic [7:0]  w_b;
    logic [15:0] w_h;

    assign w_head_f3  = r_f3_mem[r_rptr];
    assign w_head_off = r_off_mem[r_rptr];
    assign w_b = w_head_off == 2'd0 ? w_head_data[7:0]   :
                 w_head_off == 2'd1 ? w_head_data[15:8]  :
                 w_head_off == 2'd2 ? w_head_data[23:16] : w_head_data[31:24];
    assign w_h = w_head_off[1] ? w_head_data[31:16] : w_head_data[15:0];

    // Extend the head entry by load type; reserved encodings behave as a full word.
    always_comb begin
        case (w_head_f3)
            3'b000:  w_load_data = {{24{w_b[7]}}, w_b};
            3'b001:  w_load_data = {{16{w_h[15]}}, w_h};
            3'b100:  w_load_data = {24'd0, w_b};
            3'b101:  w_load_data = {16'd0, w_h};
            default: w_load_data = w_head_data;
        endcase
    end

    // Load type and offset travel with the entry so extension happens at dequeue.
    always_ff @(posedge clk) begin
        if (rst_n && w_enq) begin
            r_f3_mem[r_wptr]  <= lsu_funct3_i;
            r_off_mem[r_wptr] <= lsu_offset_i;
        end
    end
`else
    logic w_unused_ext;

    assign w_unused_ext = ^{lsu_funct3_i, lsu_offset_i};
    assign w_load_data  = w_head_data;
`endif

    // Capture an accepted load into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (rst_n && w_enq) begin
            r_rd_mem[r_wptr]   <= lsu_rd_i;
            r_data_mem[r_wptr] <= lsu_rdata_i;
        end
    end

    // Circular pointers wrap naturally (depth is a power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_deq)
                r_rptr <= r_rptr + PTR_W'(1);
            if (w_enq && !w_deq)
                r_count <= r_count + CNT_W'(1);
            else if (!w_enq && w_deq)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // Registered write port: buffered load first, else ALU; rd 0 updates address/data
    // but never asserts the write enable; idle cycles hold address/data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_deq) begin
            r_we    <= w_head_rd != '0;
            r_waddr <= w_head_rd;
            r_wdata <= DATA_WIDTH'(w_load_data);
        end else if (w_alu_xfer) begin
            r_we    <= alu_rd_i != '0;
            r_waddr <= alu_rd_i;
            r_wdata <= alu_result_i;
        end else begin
            r_we    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: queue-based reference model with per-cycle compare, directed
// literal scenarios and randomized protocol-respecting traffic for writeback_unit.
module tb_writeback_unit;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_result = '0;
    logic          lsu_valid = 1'b0;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd = '0;
    logic [31:0]   lsu_rdata = '0;
    logic [2:0]    lsu_funct3 = '0;
    logic [1:0]    lsu_offset = '0;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          we;
    logic          busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    writeback_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSU_FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rd_i(alu_rd), .alu_result_i(alu_result),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_rdata_i(lsu_rdata),
        .lsu_funct3_i(lsu_funct3), .lsu_offset_i(lsu_offset),
        .waddr_o(waddr), .wdata_o(wdata), .we_o(we), .busy_o(busy)
    );

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [31:0]   data;
        logic [2:0]    f3;
        logic [1:0]    off;
    } ld_t;

    ld_t           q[$];
    logic          m_we = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    bit            alu_fire = 0;
    bit            lsu_fire = 0;
    bit            chk_en = 0;

    function automatic logic [31:0] ext(ld_t l);
`ifdef WB_LOAD_EXT_EN
        logic [7:0]  b;
        logic [15:0] h;
        b = l.data[8*l.off +: 8];
        h = l.data[16*l.off[1] +: 16];
        case (l.f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return l.data;
        endcase
`else
        return l.data;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: loads queue in arrival order, the queue head always wins the port.
    always @(posedge clk) begin
        int n;
        ld_t h;
        alu_fire = 0;
        lsu_fire = 0;
        if (!rst_n) begin
            q.delete();
            m_we = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            n = q.size();
            lsu_fire = lsu_valid && n < D;
            alu_fire = alu_valid && n == 0;
            if (n > 0) begin
                h = q.pop_front();
                m_we = h.rd != 0;
                m_waddr = h.rd;
                m_wdata = ext(h);
            end else if (alu_fire) begin
                m_we = alu_rd != 0;
                m_waddr = alu_rd;
                m_wdata = alu_result;
            end else begin
                m_we = 1'b0;
            end
            if (lsu_fire)
                q.push_back('{rd: lsu_rd, data: lsu_rdata, f3: lsu_funct3, off: lsu_offset});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("we", 32'(we), 32'(m_we));
            chk("waddr", 32'(waddr), 32'(m_waddr));
            chk("wdata", wdata, m_wdata);
            chk("alu_ready", 32'(alu_ready), 32'(q.size() == 0));
            chk("lsu_ready", 32'(lsu_ready), 32'(q.size() < D));
            chk("busy", 32'(busy), 32'(q.size() != 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] rd, input logic [31:0] d, input logic [2:0] f3, input logic [1:0] off);
        lsu_valid = 1'b1;
        lsu_rd = rd;
        lsu_rdata = d;
        lsu_funct3 = f3;
        lsu_offset = off;
    endtask

    logic [2:0]  e_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b111};
    logic [1:0]  e_off [5] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
`ifdef WB_LOAD_EXT_EN
    logic [31:0] e_exp [5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
`else
    logic [31:0] e_exp [5] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif

    initial begin
        step();
        chk_en = 1;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        // ALU write with one-cycle latency, then rd 0 suppressing the enable
        step();
        alu_valid = 1'b1; alu_rd = 5; alu_result = 32'h1234_5678;
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_we", 32'(we), 32'd1);
        chk("alu_waddr", 32'(waddr), 32'd5);
        chk("alu_wdata", wdata, 32'h1234_5678);
        step();
        chk("alu_we_drop", 32'(we), 32'd0);
        alu_valid = 1'b1; alu_rd = 0; alu_result = 32'hDEAD_BEEF;
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_rd0_we", 32'(we), 32'd0);
        chk("alu_rd0_wdata", wdata, 32'hDEAD_BEEF);

        // Load extension cases, two-cycle latency, no bypass
        for (int i = 0; i < 5; i++) begin
            step();
            load(7, 32'h80FF_7F01, e_f3[i], e_off[i]);
            step();
            lsu_valid = 1'b0;
            @(negedge clk);
            chk("ld_nobypass_we", 32'(we), 32'd0);
            chk("ld_busy", 32'(busy), 32'd1);
            step();
            @(negedge clk);
            chk("ld_we", 32'(we), 32'd1);
            chk("ld_waddr", 32'(waddr), 32'd7);
            chk("ld_wdata", wdata, e_exp[i]);
            chk("ld_busy_fall", 32'(busy), 32'd0);
        end

        // Priority: buffered load stalls the ALU, then the ALU follows
        step();
        load(3, 32'hAAAA_0003, 3'b010, 2'd0);
        step();
        lsu_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 4; alu_result = 32'h0000_0044;
        @(negedge clk);
        chk("pri_alu_ready", 32'(alu_ready), 32'd0);
        step();
        @(negedge clk);
        chk("pri_load_waddr", 32'(waddr), 32'd3);
        chk("pri_alu_ready_back", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("pri_alu_waddr", 32'(waddr), 32'd4);
        chk("pri_alu_wdata", wdata, 32'h0000_0044);

        // Back-to-back loads across pointer wrap
        step();
        for (int i = 0; i < 5; i++) begin
            load(AW'(10 + i), 32'(i * 3 + 1), 3'b010, 2'd0);
            step();
            @(negedge clk);
            chk("b2b_lsu_ready", 32'(lsu_ready), 32'd1);
            if (i > 0)
                chk("b2b_order", 32'(waddr), 32'(9 + i));
            #1;
        end
        lsu_valid = 1'b0;
        step();
        @(negedge clk);
        chk("b2b_last", 32'(waddr), 32'd14);
        step();
        @(negedge clk);
        chk("b2b_busy_fall", 32'(busy), 32'd0);

        // Reset mid-operation discards buffered and in-flight loads
        step();
        load(20, 32'h0000_0020, 3'b010, 2'd0);
        step();
        load(21, 32'h0000_0021, 3'b010, 2'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        lsu_valid = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_we", 32'(we), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("mrst_never_written", 32'(we), 32'd0);
        end

        // Randomized traffic; producers hold valid and payload until their transfer
        step();
        for (int c = 0; c < 3000; c++) begin
            rst_n = $urandom_range(0, 299) != 0;
            if (!alu_valid || alu_fire) begin
                alu_valid = $urandom_range(0, 2) != 0;
                alu_rd = $urandom_range(0, 3) == 0 ? '0 : AW'($urandom);
                alu_result = $urandom;
            end
            if (!lsu_valid || lsu_fire) begin
                lsu_valid = $urandom_range(0, 1) != 0;
                lsu_rd = $urandom_range(0, 3) == 0 ? '0 : AW'($urandom);
                lsu_rdata = $urandom;
                lsu_funct3 = 3'($urandom);
                lsu_offset = 2'($urandom);
            end
            step();
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        rst_n = 1'b1;
        repeat (4) step();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
